// File: rtl/cordic_req_sched.sv
// Round-robin sequencer sharing one CORDIC cart-to-polar core between two
// requesters: latches operands, times Start_Pulse and core latency, captures results.
module cordic_req_sched #(
  parameter int W        = 9,
  parameter int TW       = 8,
  parameter int CORE_LAT = 16,
  parameter int START_W  = 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          REQ0,
  input  logic          REQ1,
  input  logic [W-1:0]  X0,
  input  logic [W-1:0]  X1,
  input  logic [W-1:0]  Y0,
  input  logic [W-1:0]  Y1,
  input  logic [TW-1:0] THE0,
  input  logic [TW-1:0] THE1,
  output logic          ACK0,
  output logic          ACK1,
  output logic          DONE0,
  output logic          DONE1,
  output logic [W-1:0]  RES_X,
  output logic [W-1:0]  RES_Y,
  output logic [TW-1:0] RES_THE,
  output logic          BUSY,
  output logic          Start_Pulse,
  output logic [W-1:0]  InpX,
  output logic [W-1:0]  InpY,
  output logic [TW-1:0] Inp_The,
  input  logic [W-1:0]  OTPX,
  input  logic [W-1:0]  OTPY,
  input  logic [TW-1:0] Theta_Pre
);

  localparam logic [7:0] START_LD = 8'(START_W - 1);
  localparam logic [7:0] LAT_LD   = 8'(CORE_LAT - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

  state_t        state, state_n;
  logic [7:0]    cnt, cnt_n;
  logic          last, last_n;
  logic          owner, owner_n;
  logic          gnt;
  logic [1:0]    ack_n, done_n;
  logic          start_n, busy_n;
  logic [W-1:0]  inp_x_n, inp_y_n, res_x_n, res_y_n;
  logic [TW-1:0] inp_the_n, res_the_n;

  // On contention the port that did not win last time goes next.
  assign gnt = (REQ0 && REQ1) ? ~last : REQ1;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    last_n    = last;
    owner_n   = owner;
    ack_n     = 2'b00;
    done_n    = 2'b00;
    start_n   = Start_Pulse;
    inp_x_n   = InpX;
    inp_y_n   = InpY;
    inp_the_n = Inp_The;
    res_x_n   = RES_X;
    res_y_n   = RES_Y;
    res_the_n = RES_THE;
    case (state)
      IDLE: begin
        if (REQ0 || REQ1) begin
          inp_x_n    = gnt ? X1 : X0;
          inp_y_n    = gnt ? Y1 : Y0;
          inp_the_n  = gnt ? THE1 : THE0;
          ack_n[gnt] = 1'b1;
          start_n    = 1'b1;
          cnt_n      = START_LD;
          owner_n    = gnt;
          last_n     = gnt;
          state_n    = LAUNCH;
        end
      end
      LAUNCH: begin
        if (cnt == 8'd0) begin
          start_n = 1'b0;
          cnt_n   = LAT_LD;
          state_n = WAIT;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      WAIT: begin
        if (cnt == 8'd0) begin
          res_x_n        = OTPX;
          res_y_n        = OTPY;
          res_the_n      = Theta_Pre;
          done_n[owner]  = 1'b1;
          state_n        = IDLE;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      last        <= 1'b1;
      owner       <= 1'b0;
      ACK0        <= 1'b0;
      ACK1        <= 1'b0;
      DONE0       <= 1'b0;
      DONE1       <= 1'b0;
      BUSY        <= 1'b0;
      Start_Pulse <= 1'b0;
      InpX        <= '0;
      InpY        <= '0;
      Inp_The     <= '0;
      RES_X       <= '0;
      RES_Y       <= '0;
      RES_THE     <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      last        <= last_n;
      owner       <= owner_n;
      ACK0        <= ack_n[0];
      ACK1        <= ack_n[1];
      DONE0       <= done_n[0];
      DONE1       <= done_n[1];
      BUSY        <= busy_n;
      Start_Pulse <= start_n;
      InpX        <= inp_x_n;
      InpY        <= inp_y_n;
      Inp_The     <= inp_the_n;
      RES_X       <= res_x_n;
      RES_Y       <= res_y_n;
      RES_THE     <= res_the_n;
    end
  end

endmodule

// File: doc/cordic_req_sched.md
Name: cordic_req_sched

Overview:
- Sequencer/arbiter that shares one 9-bit CORDIC cart-to-polar core (Main) between two requesters.
- Accepts operand requests and arbitrates round-robin.
- Drives the core's InpX/InpY/Inp_The/Start_Pulse, waits the core's fixed iteration latency, then captures OTPX/OTPY/Theta_Pre into a result register and signals the owning requester.
- Sits directly between the requesting logic and Main; replaces hand-generated Start_Pulse timing.

Parameters:
- W, 9, operand/result width (X, Y).
- TW, 8, angle width.
- CORE_LAT, 16, clock cycles from Start_Pulse deassertion to valid core outputs; legal range 1..255.
- START_W, 1, Start_Pulse width in clock cycles; legal range 1..15.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- REQ0, REQ1  in  1 each  request from port 0/1; held high with operands stable until the matching ACK.
- X0, X1  in  W each  X operand, port 0/1.
- Y0, Y1  in  W each  Y operand, port 0/1.
- THE0, THE1  in  TW each  initial angle, port 0/1.
- ACK0, ACK1  out  1 each  one-cycle pulse: operands latched.
- DONE0, DONE1  out  1 each  one-cycle pulse: RES_* holds this port's result.
- RES_X  out  W  captured OTPX.
- RES_Y  out  W  captured OTPY.
- RES_THE  out  TW  captured Theta_Pre.
- BUSY  out  1  high whenever state is not IDLE.
- Start_Pulse  out  1  core start.
- InpX  out  W  core X operand (registered).
- InpY  out  W  core Y operand (registered).
- Inp_The  out  TW  core angle operand (registered).
- OTPX  in  W  core X output.
- OTPY  in  W  core Y output.
- Theta_Pre  in  TW  core angle output.

Behaviour:
- Reset (async, RST_N=0):
  - State IDLE; all outputs 0, including Start_Pulse, InpX/InpY/Inp_The, RES_* and ACK/DONE.
  - Counter 0; last-grant pointer = 1, so port 0 wins the first contention.
- FSM states: IDLE, LAUNCH, WAIT. All outputs are registered.
- IDLE:
  - If neither REQ is high, stay in IDLE.
  - Only REQ0 high: grant 0. Only REQ1 high: grant 1.
  - Both high: grant the port not equal to the last-grant pointer.
  - On a grant, at the same edge:
    - InpX/InpY/Inp_The <= granted operands.
    - ACKg <= 1; Start_Pulse <= 1; cnt <= START_W-1.
    - owner <= g; last-grant <= g; go to LAUNCH.
- LAUNCH:
  - ACKg drops after one cycle.
  - If cnt==0: Start_Pulse <= 0, cnt <= CORE_LAT-1, go to WAIT. Otherwise cnt decrements.
- WAIT:
  - If cnt==0: RES_X/RES_Y/RES_THE <= OTPX/OTPY/Theta_Pre, DONE[owner] <= 1, go to IDLE. Otherwise cnt decrements.
- Timing:
  - For a REQ sampled at edge k, ACK is high in cycle k+1.
  - Start_Pulse is high for exactly START_W cycles.
  - Capture happens at edge k+START_W+CORE_LAT; DONE is high for the following one cycle.
  - The next grant can occur at edge k+START_W+CORE_LAT+1, so back-to-back throughput is one operation per START_W+CORE_LAT+1 cycles (18 with defaults).
- Operand handling:
  - InpX/InpY/Inp_The stay constant from grant until the next grant; the core sees stable operands for the whole computation.
- Result handling:
  - RES_* hold their value until the next capture.
  - DONE0 and DONE1 are never high together; ACK0 and ACK1 are never high together.
- REQ handling:
  - REQ is only sampled in IDLE.
  - A REQ still high after its ACK is treated as a new request at the next IDLE. The requester must drop REQ in the ACK cycle to avoid a duplicate.
  - A REQ that drops before it is granted is lost; no state is kept for it.
- Fairness: with both REQs continuously high, grants alternate 0,1,0,1…
- Arithmetic: no arithmetic on the data. Operands and results pass through unmodified, unsigned or signed as the core defines. The cycle counter is 8 bits.
- Reset mid-operation: everything returns to reset values immediately, the in-flight result is discarded, and no DONE is issued. After release, the FSM restarts in IDLE with port-0 priority.

Test Plan:
- Single request:
  - Stimulus: reset, then REQ0 with X0=0, Y0=100, THE0=0; behavioural core model with CORE_LAT=16 returns OTPX=100, Theta_Pre=64.
  - Required: ACK0 one cycle after REQ sampled; Start_Pulse high exactly 1 cycle; DONE0 18 cycles after the REQ edge; RES_X=100, RES_THE=64; BUSY low afterwards.
- Simultaneous first requests:
  - Stimulus: REQ0 and REQ1 rise on the same edge.
  - Required: port 0 is ACKed first; port 1 is ACKed at the first IDLE after DONE0.
  - Required: each DONE carries its own port's result (X0=10,Y0=90 vs X1=90,Y1=10, distinguishable in the model).
- Fairness and throughput:
  - Stimulus: hold both REQs high for 6 operations.
  - Required: grant order 0,1,0,1,0,1; ACK spacing exactly 18 cycles; ACK0/ACK1 and DONE0/DONE1 never coincident.
- Reset mid-operation:
  - Stimulus: assert RST_N=0 during WAIT (cnt=7).
  - Required: Start_Pulse, BUSY and RES_* go to 0 asynchronously; no DONE is issued.
  - Required: after release, a pending REQ1 alone is granted normally.
- Parameter variant:
  - Stimulus: START_W=3, CORE_LAT=4, REQ1 with X1=50, Y1=50.
  - Required: Start_Pulse high for 3 cycles; InpX/InpY stable across the whole operation; DONE1 at edge k+7.
- Stuck request:
  - Stimulus: REQ0 left high after ACK0.
  - Required: a second ACK0 exactly 18 cycles after the first (duplicate launch).
  - Required: after REQ0 drops during that second ACK cycle, no third grant occurs.
